pix_pack: RTL

- Pixel-domain front end of the video_mix write path.
- Captures 16-bit active-video pixels from the input decoder and packs 8 pixels into one 128-bit word.
- Tags the first word of every 512-pixel segment and pushes 129-bit words into the async write FIFO read by the DRAM write engine.
- Drives the line number (cline) and segment index (cpxl) consumed with each segment.

---
 rtl/pix_pack_if.sv | 25 ++
 rtl/pix_pack.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pix_pack_if.sv
// pix_pack_if: write-FIFO side of the pixel packer.
// Carries the 129-bit word, push strobe, full and segment tags.
interface pix_pack_if;
  logic         fifo_wr_en;
  logic [128:0] fifo_din;
  logic         fifo_full;
  logic [11:0]  cline;
  logic [1:0]   cpxl;

  modport master (
    output fifo_wr_en,
    output fifo_din,
    output cline,
    output cpxl,
    input  fifo_full
  );

  modport slave (
    input  fifo_wr_en,
    input  fifo_din,
    input  cline,
    input  cpxl,
    output fifo_full
  );
endinterface

// File: rtl/pix_pack.sv
// pix_pack: packs 16-bit active pixels into 128-bit words and
// pushes segment-tagged words into the DRAM write FIFO.
module pix_pack #(
  parameter int PWIDTH   = 16,
  parameter int H_ACTIVE = 1024,
  parameter int SEG_PIX  = 512,
  parameter int MAX_SEG  = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              de,
  input  logic [PWIDTH-1:0] pdata,
  pix_pack_if.master        fifo,
  output logic              overflow,
  output logic              frame_start
);
  localparam int LANES = 128 / PWIDTH;
  localparam logic [10:0] L_HACT = 11'(H_ACTIVE);
  localparam logic [10:0] L_SEG  = 11'(SEG_PIX);
  localparam logic [10:0] L_MAXS = 11'(MAX_SEG);
  localparam logic [10:0] L_LNS  = 11'(LANES);

  logic         r_vsync_d;
  logic         r_de_d;
  logic         r_seen0;
  logic         r_act;
  logic         r_fs;
  logic         r_ovf;
  logic [10:0]  r_pix_cnt;
  logic [11:0]  r_line_cnt;
  logic [127:0] r_pack;
  logic         r_pend;
  logic [128:0] r_din;
  logic [11:0]  r_pline;
  logic [1:0]   r_pseg;
  logic [11:0]  r_cline;
  logic [1:0]   r_cpxl;

  logic         w_fs;
  logic         w_de_rise;
  logic         w_de_fall;
  logic         w_start;
  logic         w_acc;
  logic [10:0]  w_idx;
  logic [2:0]   w_lane;
  logic [127:0] w_pack_nx;
  logic         w_fpush;
  logic         w_flush;
  logic [10:0]  w_base;
  logic [10:0]  w_seg;
  logic [10:0]  w_off;
  logic         w_mark;
  logic         w_commit;
  logic         w_push;
  logic         w_drop;
  logic         w_mpush;

  assign w_fs      = vsync & ~r_vsync_d;
  assign w_de_rise = de & ~r_de_d;
  assign w_de_fall = ~de & r_de_d;
  // A line only starts on a rise seen after de was low post-reset
  assign w_start   = w_de_rise & r_seen0;
  assign w_idx     = w_start ? 11'd0 : r_pix_cnt;
  assign w_lane    = w_idx[2:0];
  assign w_acc     = de & (w_start | r_act) & (w_idx < L_HACT);

  // Lane 0 of a word starts from a clean register so a flush zero-fills
  always_comb begin
    w_pack_nx = (w_lane == 3'd0) ? '0 : r_pack;
    w_pack_nx[w_lane*PWIDTH +: PWIDTH] = pdata;
  end

  assign w_fpush  = w_acc & (w_lane == 3'(LANES - 1));
  assign w_flush  = w_de_fall & (r_pix_cnt[2:0] != 3'd0);
  assign w_base   = w_fpush ? w_idx : r_pix_cnt;
  assign w_seg    = w_base / L_SEG;
  assign w_off    = w_base % L_SEG;
  assign w_mark   = w_off < L_LNS;
  assign w_commit = (w_fpush | w_flush) & (w_seg < L_MAXS);

  // Full is judged in the cycle the push is presented
  assign w_push  = r_pend & ~fifo.fifo_full;
  assign w_drop  = r_pend & fifo.fifo_full;
  assign w_mpush = w_push & r_din[128];

  assign fifo.fifo_wr_en = w_push;
  assign fifo.fifo_din   = r_din;
  assign fifo.cline      = w_mpush ? r_pline : r_cline;
  assign fifo.cpxl       = w_mpush ? r_pseg : r_cpxl;
  assign overflow        = r_ovf;
  assign frame_start     = r_fs;

  // Sync/de history, line-active tracking and frame pulse
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_de_d    <= 1'b0;
      r_seen0   <= 1'b0;
      r_act     <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      r_de_d    <= de;
      r_seen0   <= r_seen0 | ~de;
      r_fs      <= w_fs;
      if (!de)
        r_act <= 1'b0;
      else if (w_start)
        r_act <= 1'b1;
    end
  end

  // Pixel and line counters; frame start clears both
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else begin
      if (w_fs)
        r_pix_cnt <= '0;
      else if (w_acc)
        r_pix_cnt <= w_idx + 11'd1;
      if (w_fs)
        r_line_cnt <= '0;
      else if (w_de_fall)
        r_line_cnt <= r_line_cnt + 12'd1;
    end
  end

  // Pack register lane writes
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      r_pack <= '0;
    else if (w_acc)
      r_pack <= w_pack_nx;
  end

  // Stage the completed or flushed word with its tags
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_din   <= '0;
      r_pline <= '0;
      r_pseg  <= '0;
    end else begin
      r_pend <= w_commit;
      if (w_commit) begin
        r_din   <= {w_mark, w_fpush ? w_pack_nx : r_pack};
        r_pline <= r_line_cnt;
        r_pseg  <= w_seg[1:0];
      end
    end
  end

  // Hold segment tags after a marker push; sticky overflow
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cline <= '0;
      r_cpxl  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_mpush) begin
        r_cline <= r_pline;
        r_cpxl  <= r_pseg;
      end
      if (w_fs)
        r_ovf <= 1'b0;
      else if (w_drop)
        r_ovf <= 1'b1;
    end
  end
endmodule
